decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 75 +++++++
 rtl/decode_stage_regfile.sv | 48 ++++
 rtl/decode_stage.sv | 97 +++++++++
 tb/tb_decode_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: ALU operation codes, RV32I opcode/funct constants
// and the instruction classifier used by the decode stage.
package decode_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_OR  = 4'd9,
    ALU_AND = 4'd10
  } alu_op_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef struct packed {
    logic    legal;
    logic    use_imm;
    alu_op_e op;
  } decode_t;

  function automatic decode_t decode_instr(input logic [31:0] instr);
    decode_t    res;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    opcode      = instr[6:0];
    funct3      = instr[14:12];
    funct7      = instr[31:25];
    res.legal   = 1'b0;
    res.use_imm = 1'b0;
    res.op      = ALU_ADD;
    if (opcode == OP_R) begin
      if (funct3 == F3_ADD_SUB && funct7 == F7_BASE) begin
        res.legal = 1'b1;
        res.op    = ALU_ADD;
      end else if (funct3 == F3_ADD_SUB && funct7 == F7_SUB) begin
        res.legal = 1'b1;
        res.op    = ALU_SUB;
      end else if (funct3 == F3_OR && funct7 == F7_BASE) begin
        res.legal = 1'b1;
        res.op    = ALU_OR;
      end else if (funct3 == F3_AND && funct7 == F7_BASE) begin
        res.legal = 1'b1;
        res.op    = ALU_AND;
      end
    end else if (opcode == OP_I) begin
      // funct7 bits are part of the immediate here, so they are not checked
      res.use_imm = 1'b1;
      if (funct3 == F3_ADD_SUB) begin
        res.legal = 1'b1;
        res.op    = ALU_ADD;
      end else if (funct3 == F3_OR) begin
        res.legal = 1'b1;
        res.op    = ALU_OR;
      end else if (funct3 == F3_AND) begin
        res.legal = 1'b1;
        res.op    = ALU_AND;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// 32 x N register file: two combinational read ports with write-through bypass,
// one write port, x0 hardwired to zero, all entries cleared on reset.
module regfile #(
  parameter int N = 32
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         we,
  input  logic [4:0]   waddr,
  input  logic [N-1:0] wdata,
  input  logic [4:0]   raddr_a,
  input  logic [4:0]   raddr_b,
  output logic [N-1:0] rdata_a,
  output logic [N-1:0] rdata_b
);

  logic [N-1:0] mem_q [32];
  logic [4:0]   raddr [2];
  logic [N-1:0] rdata [2];

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;
  assign rdata_a  = rdata[0];
  assign rdata_b  = rdata[1];

  always_ff @(posedge clock) begin
    if (!nreset) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we && waddr != 5'd0) begin
      mem_q[waddr] <= wdata;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_read
    // A same-cycle write to the addressed register wins over the stored value
    always_comb begin
      rdata[gi] = mem_q[raddr[gi]];
      if (raddr[gi] == 5'd0) begin
        rdata[gi] = '0;
      end else if (we && waddr == raddr[gi]) begin
        rdata[gi] = wdata;
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage for ADD/SUB/OR/AND (R and I forms): reads operands from the
// register file and holds them in a one-entry valid/ready output register.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int n = 32
) (
  input  logic         clock,
  input  logic         nreset,
  input  logic         InstrValid,
  output logic         InstrReady,
  input  logic [31:0]  Instr,
  input  logic         WbEn,
  input  logic [4:0]   WbAddr,
  input  logic [n-1:0] WbData,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [3:0]   AluOp,
  output logic [n-1:0] A,
  output logic [n-1:0] B,
  output logic [4:0]   Rd,
  output logic         IllegalInstr
);

  state_e       state_q, state_d;
  alu_op_e      alu_op_q, alu_op_d;
  logic [n-1:0] a_q, a_d;
  logic [n-1:0] b_q, b_d;
  logic [4:0]   rd_q, rd_d;
  logic         illegal_q, illegal_d;

  logic [n-1:0] rdata_a, rdata_b;
  logic [n-1:0] imm_ext;
  logic         accept;
  decode_t      dec;

  regfile #(.N(n)) u_regfile (
    .clock   (clock),
    .nreset  (nreset),
    .we      (WbEn),
    .waddr   (WbAddr),
    .wdata   (WbData),
    .raddr_a (Instr[19:15]),
    .raddr_b (Instr[24:20]),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b)
  );

  assign InstrReady = !nreset || (state_q == ST_EMPTY) || OutReady;
  assign accept     = InstrValid && InstrReady;
  assign imm_ext    = {{(n-12){Instr[31]}}, Instr[31:20]};

  always_comb begin
    dec       = decode_instr(Instr);
    state_d   = state_q;
    alu_op_d  = alu_op_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    illegal_d = accept && !dec.legal;
    if (accept && dec.legal) begin
      state_d  = ST_FULL;
      alu_op_d = dec.op;
      a_d      = rdata_a;
      b_d      = dec.use_imm ? imm_ext : rdata_b;
      rd_d     = Instr[11:7];
    end else if (OutReady) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_q   <= ST_EMPTY;
      alu_op_q  <= ALU_ADD;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      alu_op_q  <= alu_op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
    end
  end

  assign OutValid     = (state_q == ST_FULL);
  assign AluOp        = alu_op_q;
  assign A            = a_q;
  assign B            = b_q;
  assign Rd           = rd_q;
  assign IllegalInstr = illegal_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a vector table for single-cycle behaviour
// plus hand sequences for stall/back-to-back and reset while full.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        nreset;
  logic        InstrValid;
  logic        InstrReady;
  logic [31:0] Instr;
  logic        WbEn;
  logic [4:0]  WbAddr;
  logic [31:0] WbData;
  logic        OutValid;
  logic        OutReady;
  logic [3:0]  AluOp;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  Rd;
  logic        IllegalInstr;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  decode_stage #(.n(32)) dut (
    .clock        (clock),
    .nreset       (nreset),
    .InstrValid   (InstrValid),
    .InstrReady   (InstrReady),
    .Instr        (Instr),
    .WbEn         (WbEn),
    .WbAddr       (WbAddr),
    .WbData       (WbData),
    .OutValid     (OutValid),
    .OutReady     (OutReady),
    .AluOp        (AluOp),
    .A            (A),
    .B            (B),
    .Rd           (Rd),
    .IllegalInstr (IllegalInstr)
  );

  typedef struct {
    logic        iv;
    logic [31:0] instr;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        exp_valid;
    logic [3:0]  exp_op;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [4:0]  exp_rd;
    logic        exp_ill;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic vec_t mk(input logic iv, input logic [31:0] instr, input logic wb_en,
                              input logic [4:0] wb_addr, input logic [31:0] wb_data,
                              input logic exp_valid, input logic [3:0] exp_op,
                              input logic [31:0] exp_a, input logic [31:0] exp_b,
                              input logic [4:0] exp_rd, input logic exp_ill);
    vec_t v;
    v.iv = iv; v.instr = instr; v.wb_en = wb_en; v.wb_addr = wb_addr; v.wb_data = wb_data;
    v.exp_valid = exp_valid; v.exp_op = exp_op; v.exp_a = exp_a; v.exp_b = exp_b;
    v.exp_rd = exp_rd; v.exp_ill = exp_ill;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
    chk({tag, " AluOp"}, 32'(AluOp), 32'(op));
    chk({tag, " A"}, A, a);
    chk({tag, " B"}, B, b);
    chk({tag, " Rd"}, 32'(Rd), 32'(rd));
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0]  = mk(0, 32'h0, 1, 5'd1, 32'd5, 0, 4'd0, 0, 0, 5'd0, 0);
    vecs[1]  = mk(0, 32'h0, 1, 5'd2, 32'd7, 0, 4'd0, 0, 0, 5'd0, 0);
    vecs[2]  = mk(1, r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd3), 0, 5'd0, 0,
                  1, 4'd0, 32'd5, 32'd7, 5'd3, 0);
    vecs[3]  = mk(1, i_type(12'hFFF, 5'd1, 3'b000, 5'd4), 0, 5'd0, 0,
                  1, 4'd0, 32'd5, 32'hFFFF_FFFF, 5'd4, 0);
    vecs[4]  = mk(1, r_type(7'h20, 5'd1, 5'd2, 3'b000, 5'd5), 0, 5'd0, 0,
                  1, 4'd1, 32'd7, 32'd5, 5'd5, 0);
    vecs[5]  = mk(1, r_type(7'h00, 5'd0, 5'd6, 3'b110, 5'd7), 1, 5'd6, 32'hDEAD,
                  1, 4'd9, 32'hDEAD, 32'd0, 5'd7, 0);
    vecs[6]  = mk(1, r_type(7'h00, 5'd2, 5'd6, 3'b111, 5'd8), 0, 5'd0, 0,
                  1, 4'd10, 32'hDEAD, 32'd7, 5'd8, 0);
    vecs[7]  = mk(1, i_type(12'h0F0, 5'd2, 3'b110, 5'd9), 0, 5'd0, 0,
                  1, 4'd9, 32'd7, 32'h0F0, 5'd9, 0);
    vecs[8]  = mk(1, i_type(12'h0FF, 5'd6, 3'b111, 5'd10), 0, 5'd0, 0,
                  1, 4'd10, 32'hDEAD, 32'h0FF, 5'd10, 0);
    vecs[9]  = mk(0, 32'h0, 1, 5'd0, 32'h1234, 0, 4'd0, 0, 0, 5'd0, 0);
    vecs[10] = mk(1, r_type(7'h00, 5'd2, 5'd0, 3'b000, 5'd11), 1, 5'd0, 32'h4321,
                  1, 4'd0, 32'd0, 32'd7, 5'd11, 0);
    vecs[11] = mk(1, 32'h0000_0073, 0, 5'd0, 0, 0, 4'd0, 0, 0, 5'd0, 1);
    vecs[12] = mk(0, 32'h0, 0, 5'd0, 0, 0, 4'd0, 0, 0, 5'd0, 0);
    vecs[13] = mk(1, r_type(7'h20, 5'd1, 5'd2, 3'b110, 5'd5), 0, 5'd0, 0,
                  0, 4'd0, 0, 0, 5'd0, 1);
    vecs[14] = mk(1, r_type(7'h00, 5'd1, 5'd1, 3'b000, 5'd12), 1, 5'd1, 32'h8000_0000,
                  1, 4'd0, 32'h8000_0000, 32'h8000_0000, 5'd12, 0);
    vecs[15] = mk(0, 32'h0, 0, 5'd0, 0, 0, 4'd0, 0, 0, 5'd0, 0);

    nreset = 1'b0; InstrValid = 1'b0; Instr = '0; WbEn = 1'b0;
    WbAddr = '0; WbData = '0; OutReady = 1'b1;
    tick();
    tick();
    chk("reset OutValid", 32'(OutValid), 32'd0);
    chk("reset Illegal", 32'(IllegalInstr), 32'd0);
    chk("reset InstrReady", 32'(InstrReady), 32'd1);
    chk_out("reset", 4'd0, 32'd0, 32'd0, 5'd0);
    $display("reset released");
    nreset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      InstrValid = vecs[i].iv; Instr = vecs[i].instr; OutReady = 1'b1;
      WbEn = vecs[i].wb_en; WbAddr = vecs[i].wb_addr; WbData = vecs[i].wb_data;
      #1;
      chk($sformatf("vec%0d InstrReady", i), 32'(InstrReady), 32'd1);
      tick();
      chk($sformatf("vec%0d OutValid", i), 32'(OutValid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d Illegal", i), 32'(IllegalInstr), 32'(vecs[i].exp_ill));
      if (vecs[i].exp_valid)
        chk_out($sformatf("vec%0d", i), vecs[i].exp_op, vecs[i].exp_a, vecs[i].exp_b,
                vecs[i].exp_rd);
      $display("vec %0d instr=%h valid=%0d op=%0d A=%h B=%h rd=%0d ill=%0d",
               i, vecs[i].instr, OutValid, AluOp, A, B, Rd, IllegalInstr);
    end

    // Stall: SUB x13,x6,x2 held for 3 cycles while a second ADD waits and x6 is rewritten
    InstrValid = 1'b1; Instr = r_type(7'h20, 5'd2, 5'd6, 3'b000, 5'd13);
    OutReady = 1'b0; WbEn = 1'b0;
    tick();
    chk("stall accept OutValid", 32'(OutValid), 32'd1);
    chk_out("stall accept", 4'd1, 32'hDEAD, 32'd7, 5'd13);
    Instr = r_type(7'h00, 5'd2, 5'd6, 3'b000, 5'd14);
    WbEn = 1'b1; WbAddr = 5'd6; WbData = 32'h5555;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("stall%0d InstrReady", c), 32'(InstrReady), 32'd0);
      tick();
      WbEn = 1'b0;
      chk($sformatf("stall%0d OutValid", c), 32'(OutValid), 32'd1);
      chk_out($sformatf("stall%0d", c), 4'd1, 32'hDEAD, 32'd7, 5'd13);
      $display("stall cycle %0d op=%0d A=%h B=%h rd=%0d", c, AluOp, A, B, Rd);
    end
    OutReady = 1'b1;
    #1;
    chk("release InstrReady", 32'(InstrReady), 32'd1);
    tick();
    chk("second OutValid", 32'(OutValid), 32'd1);
    chk_out("second", 4'd0, 32'h5555, 32'd7, 5'd14);
    $display("second instr op=%0d A=%h B=%h rd=%0d", AluOp, A, B, Rd);
    InstrValid = 1'b0;
    tick();
    chk("drain OutValid", 32'(OutValid), 32'd0);

    // Reset while FULL discards the held instruction and clears the register file
    InstrValid = 1'b1; Instr = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd15); OutReady = 1'b0;
    tick();
    chk("prereset OutValid", 32'(OutValid), 32'd1);
    nreset = 1'b0; WbEn = 1'b1; WbAddr = 5'd1; WbData = 32'd99;
    #1;
    chk("inreset InstrReady", 32'(InstrReady), 32'd1);
    tick();
    chk("midreset OutValid", 32'(OutValid), 32'd0);
    chk("midreset Illegal", 32'(IllegalInstr), 32'd0);
    chk_out("midreset", 4'd0, 32'd0, 32'd0, 5'd0);
    nreset = 1'b1; WbEn = 1'b0; OutReady = 1'b1;
    Instr = r_type(7'h00, 5'd2, 5'd1, 3'b000, 5'd16);
    tick();
    chk("postreset OutValid", 32'(OutValid), 32'd1);
    chk_out("postreset", 4'd0, 32'd0, 32'd0, 5'd16);
    $display("post-reset read op=%0d A=%h B=%h rd=%0d", AluOp, A, B, Rd);
    InstrValid = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
